// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported memory, with region/alignment checks.
// Latency: gnt is combinational in IDLE and rvalid follows one cycle later. Backpressure: requesters hold until gnt; responses are never stalled.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [12:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [13:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [15:0] dm_rdata,
  output logic        dm_err,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             owner_dm;
  logic             fault_q;
  logic             pass_q;
  logic [CNT_W-1:0] starve_cnt;

  logic if_legal, dm_legal, arb, pick_if, pick_dm, resp;

  assign if_legal = ~if_addr[0];
  assign dm_legal = dm_addr[13] & ~dm_addr[0];

  // rst_n gating keeps every output low while reset is asserted.
  assign arb     = rst_n && (state == IDLE);
  assign resp    = rst_n && (state == RESP);
  assign pick_if = arb && if_req && (!dm_req || (starve_cnt >= LIMIT));
  assign pick_dm = arb && dm_req && !pick_if;

  always_comb begin
    if_gnt    = pick_if;
    dm_gnt    = pick_dm;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (pick_if && if_legal) begin
      mem_addr = {1'b0, if_addr};
    end
    if (pick_dm && dm_legal) begin
      mem_addr  = dm_addr;
      mem_we    = dm_we;
      mem_wdata = dm_wdata;
    end
    if_rvalid = resp && !owner_dm;
    dm_rvalid = resp && owner_dm;
    if_err    = if_rvalid && fault_q;
    dm_err    = dm_rvalid && fault_q;
    if_rdata  = (if_rvalid && pass_q) ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && pass_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      fault_q    <= 1'b0;
      pass_q     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_if || pick_dm) begin
            state    <= RESP;
            owner_dm <= pick_dm;
            fault_q  <= pick_dm ? !dm_legal : !if_legal;
            pass_q   <= pick_dm ? (dm_legal && !dm_we) : if_legal;
          end
        end
        default: state <= IDLE;
      endcase
      // Only arbitration (IDLE) cycles count as lost; a waiting fetch holds its count through RESP.
      if (!if_req || pick_if) begin
        starve_cnt <= '0;
      end else if (state == IDLE && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [12:0] if_addr;
  logic [15:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [13:0] dm_addr;
  logic [15:0] dm_wdata, dm_rdata;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int idx);
    return (idx == 2) ? 16'h8123 : 16'(idx * 40503 + 4951);
  endfunction

  // Physical memory seen by the DUT: one-cycle read latency.
  logic [15:0] phys [8192];
  bit          wr   [8192];
  always @(posedge clk) begin
    if (mem_we) begin
      phys[mem_addr[13:1]] <= mem_wdata;
      wr[mem_addr[13:1]]   <= 1'b1;
    end
    mem_rdata <= wr[mem_addr[13:1]] ? phys[mem_addr[13:1]] : init_word(int'(mem_addr[13:1]));
  end

  // Reference model: expected memory contents and transaction bookkeeping.
  logic [15:0] ref_mem [int];
  bit          busy;
  bit          r_dm;
  bit          r_err;
  logic [15:0] r_data;
  int          lost;
  bit          if_got, dm_got;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs applied; checks this cycle and returns at the next negedge.
  task automatic step();
    bit win_if, win_dm, legal;
    int idx;
    #1;
    if_got = 0;
    dm_got = 0;
    if (busy) begin
      check1("resp_if_gnt", if_gnt, 1'b0);
      check1("resp_dm_gnt", dm_gnt, 1'b0);
      check1("resp_mem_we", mem_we, 1'b0);
      check1("if_rvalid", if_rvalid, !r_dm);
      check1("dm_rvalid", dm_rvalid, r_dm);
      check1("if_err", if_err, !r_dm && r_err);
      check1("dm_err", dm_err, r_dm && r_err);
      check16("if_rdata", if_rdata, r_dm ? 16'h0 : r_data);
      check16("dm_rdata", dm_rdata, r_dm ? r_data : 16'h0);
      busy = 0;
      if (!if_req) lost = 0;
    end else begin
      win_if = if_req && (!dm_req || lost >= LIMIT);
      win_dm = dm_req && !win_if;
      check1("if_gnt", if_gnt, win_if);
      check1("dm_gnt", dm_gnt, win_dm);
      check1("idle_if_rvalid", if_rvalid, 1'b0);
      check1("idle_dm_rvalid", dm_rvalid, 1'b0);
      if (win_if) begin
        legal = !if_addr[0];
        idx = int'(if_addr[12:1]);
        check16("if_mem_addr", 16'(mem_addr), legal ? 16'(if_addr) : 16'h0);
        check1("if_mem_we", mem_we, 1'b0);
        r_dm = 0; r_err = !legal;
        r_data = legal ? ref_rd(idx) : 16'h0;
        if_got = 1; busy = 1;
      end else if (win_dm) begin
        legal = dm_addr[13] && !dm_addr[0];
        idx = int'(dm_addr[13:1]);
        check16("dm_mem_addr", 16'(mem_addr), legal ? 16'(dm_addr) : 16'h0);
        check1("dm_mem_we", mem_we, legal && dm_we);
        if (legal && dm_we) check16("dm_mem_wdata", mem_wdata, dm_wdata);
        r_dm = 1; r_err = !legal;
        r_data = (legal && !dm_we) ? ref_rd(idx) : 16'h0;
        if (legal && dm_we) ref_mem[idx] = dm_wdata;
        dm_got = 1; busy = 1;
      end else begin
        check16("noreq_mem_addr", 16'(mem_addr), 16'h0);
        check1("noreq_mem_we", mem_we, 1'b0);
      end
      lost = (win_if || !if_req) ? 0 : ((lost == 15) ? 15 : lost + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    busy = 0; lost = 0; r_dm = 0; r_err = 0; r_data = '0;
    repeat (2) @(negedge clk);
    check1("rst_if_rvalid", if_rvalid, 1'b0);
    check1("rst_dm_rvalid", dm_rvalid, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check16("rst_mem_addr", 16'(mem_addr), 16'h0);
    rst_n = 1'b1;
    step();

    // Fetch from 0x0004.
    if_req = 1; if_addr = 13'h0004;
    #1;
    check1("tp_fetch_gnt", if_gnt, 1'b1);
    check16("tp_fetch_addr", 16'(mem_addr), 16'h0004);
    step();
    if_req = 0;
    check1("tp_fetch_rvalid", if_rvalid, 1'b1);
    check16("tp_fetch_rdata", if_rdata, 16'h8123);
    check1("tp_fetch_err", if_err, 1'b0);
    step();

    // Data write then read back.
    dm_req = 1; dm_we = 1; dm_addr = 14'h2010; dm_wdata = 16'hBEEF;
    #1;
    check1("tp_wr_gnt", dm_gnt, 1'b1);
    check1("tp_wr_we", mem_we, 1'b1);
    step();
    dm_req = 0;
    check1("tp_wr_ack", dm_rvalid, 1'b1);
    check16("tp_wr_rdata", dm_rdata, 16'h0);
    step();
    dm_req = 1; dm_we = 0;
    step();
    dm_req = 0;
    check16("tp_rd_rdata", dm_rdata, 16'hBEEF);
    step();

    // Faults: data write into program space, odd fetch.
    dm_req = 1; dm_we = 1; dm_addr = 14'h0100; dm_wdata = 16'h1234;
    #1;
    check1("tp_dfault_gnt", dm_gnt, 1'b1);
    check1("tp_dfault_we", mem_we, 1'b0);
    step();
    dm_req = 0;
    check1("tp_dfault_rvalid", dm_rvalid, 1'b1);
    check1("tp_dfault_err", dm_err, 1'b1);
    step();
    if_req = 1; if_addr = 13'h0003;
    step();
    if_req = 0;
    check1("tp_ifault_err", if_err, 1'b1);
    step();

    // Contention: both requests held; fetch wins the fifth arbitration, then data again.
    if_req = 1; if_addr = 13'h0008;
    dm_req = 1; dm_we = 0; dm_addr = 14'h2010;
    for (int k = 0; k < 12; k++) begin
      #1;
      check1("cont_if_gnt", if_gnt, (k % 2 == 0) && (k / 2 == 4));
      check1("cont_dm_gnt", dm_gnt, (k % 2 == 0) && (k / 2 != 4));
      step();
    end
    if_req = 0; dm_req = 0;
    step();

    // Reset during RESP.
    dm_req = 1; dm_we = 0; dm_addr = 14'h2012;
    step();
    dm_req = 0; if_req = 1; if_addr = 13'h0010;
    rst_n = 1'b0;
    #1;
    check1("rstm_dm_rvalid", dm_rvalid, 1'b0);
    check16("rstm_dm_rdata", dm_rdata, 16'h0);
    check1("rstm_if_gnt", if_gnt, 1'b0);
    check16("rstm_mem_addr", 16'(mem_addr), 16'h0);
    @(negedge clk);
    check1("rstm_if_gnt_hold", if_gnt, 1'b0);
    rst_n = 1'b1;
    busy = 0; lost = 0;
    #1;
    check1("rstm_release_gnt", if_gnt, 1'b1);
    step();
    if_req = 0;
    step();

    // Random traffic.
    if_got = 1; dm_got = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!if_req || if_got) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 13'($urandom_range(0, 31) * 2 + (($urandom_range(0, 7) == 0) ? 1 : 0));
      end
      if (!dm_req || dm_got) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_wdata = 16'($urandom);
        r = $urandom_range(0, 9);
        if (r < 7)       dm_addr = 14'(16'h2000 + $urandom_range(0, 15) * 2);
        else if (r == 7) dm_addr = 14'(16'h2001 + $urandom_range(0, 15) * 2);
        else             dm_addr = 14'($urandom_range(0, 63) * 2);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
